meduram_wr_arbiter: RTL and testbench

Write-port arbiter placed in front of the 2-write/2-read `top` RAM. It shares the RAM's two write ports (`wren1/wraddr1/wrdata1`, `wren2/wraddr2/wrdata2`) between `NB_REQ` write requesters using valid/ready handshakes. Each cycle it issues up to two round-robin grants and drives the RAM write ports from registers. It can optionally suppress same-address double writes in one cycle.

---
 rtl/meduram_wr_arbiter_if.sv | 32 +++
 rtl/meduram_wr_arbiter.sv | 128 ++++++++++++
 tb/tb_meduram_wr_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/meduram_wr_arbiter_if.sv
// Requester/RAM-write-port bundle for meduram_wr_arbiter.
// slave: arbiter side; master: requesters plus RAM write-port observer.
interface meduram_wr_arbiter_if #(
    parameter int unsigned NB_REQ     = 4,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [NB_REQ-1:0]            req_valid;
    logic [NB_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NB_REQ*DATA_WIDTH-1:0] req_data;
    logic [NB_REQ-1:0]            req_ready;
    logic                         wren1;
    logic [ADDR_WIDTH-1:0]        wraddr1;
    logic [DATA_WIDTH-1:0]        wrdata1;
    logic                         wren2;
    logic [ADDR_WIDTH-1:0]        wraddr2;
    logic [DATA_WIDTH-1:0]        wrdata2;

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready,
        output wren1, wraddr1, wrdata1,
        output wren2, wraddr2, wrdata2
    );

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready,
        input  wren1, wraddr1, wrdata1,
        input  wren2, wraddr2, wrdata2
    );
endinterface

// File: rtl/meduram_wr_arbiter.sv
// Two-grant round-robin arbiter sharing the two RAM write ports among NB_REQ requesters.
// Optional MEDURAM_WR_SAME_ADDR_CHECK_EN suppresses a second same-address grant per cycle.
module meduram_wr_arbiter #(
    parameter int unsigned NB_REQ     = 4,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    meduram_wr_arbiter_if.slave   bus
`ifdef MEDURAM_WR_SAME_ADDR_CHECK_EN
    ,
    output logic [15:0]           conflict_cnt
`endif
);
    localparam int unsigned IW = $clog2(NB_REQ);
    localparam logic [IW-1:0] LAST = IW'(NB_REQ - 1);

    logic [IW-1:0]         ptr;
    logic [IW-1:0]         ptr_nxt;
    logic [IW-1:0]         idx_a;
    logic [IW-1:0]         idx_b;
    logic                  found_a;
    logic                  found_b;
    logic                  grant_b;
    logic                  same_addr;
    logic [ADDR_WIDTH-1:0] addr_arr [NB_REQ];
    logic [DATA_WIDTH-1:0] data_arr [NB_REQ];

    // Unpack the flat request buses
    always_comb begin
        for (int i = 0; i < int'(NB_REQ); i++) begin
            addr_arr[i] = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            data_arr[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Circular search from ptr: first valid is grant A, second is grant B
    always_comb begin
        int unsigned j;
        found_a = 1'b0;
        found_b = 1'b0;
        idx_a   = '0;
        idx_b   = '0;
        j       = 0;
        for (int k = 0; k < int'(NB_REQ); k++) begin
            j = int'(ptr) + k;
            if (j >= NB_REQ) begin
                j = j - NB_REQ;
            end
            if (bus.req_valid[IW'(j)]) begin
                if (!found_a) begin
                    found_a = 1'b1;
                    idx_a   = IW'(j);
                end else if (!found_b) begin
                    found_b = 1'b1;
                    idx_b   = IW'(j);
                end
            end
        end
    end

`ifdef MEDURAM_WR_SAME_ADDR_CHECK_EN
    assign same_addr = found_b && (addr_arr[idx_a] == addr_arr[idx_b]);
`else
    assign same_addr = 1'b0;
`endif

    assign grant_b = found_b && !same_addr;

    // Ready is gated by reset so nothing is accepted while held in reset
    always_comb begin
        bus.req_ready = '0;
        if (aresetn) begin
            if (found_a) begin
                bus.req_ready[idx_a] = 1'b1;
            end
            if (grant_b) begin
                bus.req_ready[idx_b] = 1'b1;
            end
        end
    end

    // Pointer moves past the last issued grant; a suppressed B stays first in line
    always_comb begin
        ptr_nxt = ptr;
        if (grant_b) begin
            ptr_nxt = (idx_b == LAST) ? '0 : idx_b + IW'(1);
        end else if (found_a) begin
            ptr_nxt = (idx_a == LAST) ? '0 : idx_a + IW'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr         <= '0;
            bus.wren1   <= 1'b0;
            bus.wraddr1 <= '0;
            bus.wrdata1 <= '0;
            bus.wren2   <= 1'b0;
            bus.wraddr2 <= '0;
            bus.wrdata2 <= '0;
        end else begin
            ptr       <= ptr_nxt;
            bus.wren1 <= found_a;
            bus.wren2 <= grant_b;
            if (found_a) begin
                bus.wraddr1 <= addr_arr[idx_a];
                bus.wrdata1 <= data_arr[idx_a];
            end
            if (grant_b) begin
                bus.wraddr2 <= addr_arr[idx_b];
                bus.wrdata2 <= data_arr[idx_b];
            end
        end
    end

`ifdef MEDURAM_WR_SAME_ADDR_CHECK_EN
    // Saturating count of suppressed same-address B grants
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            conflict_cnt <= '0;
        end else if (same_addr && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_meduram_wr_arbiter.sv
// Directed bench for meduram_wr_arbiter: reset, rotation, idle, wrap, same-address, reset mid-burst.
// Honors MEDURAM_WR_SAME_ADDR_CHECK_EN for the conflict scenario.
module tb_meduram_wr_arbiter;
    localparam int unsigned NB_REQ = 4;
    localparam int unsigned AW     = 8;
    localparam int unsigned DW     = 32;

    logic aclk = 1'b0;
    logic aresetn;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 aclk = ~aclk;

    meduram_wr_arbiter_if #(.NB_REQ(NB_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef MEDURAM_WR_SAME_ADDR_CHECK_EN
    logic [15:0] conflict_cnt;
`endif

    meduram_wr_arbiter #(.NB_REQ(NB_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .bus          (bus)
`ifdef MEDURAM_WR_SAME_ADDR_CHECK_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_p1(input string tag, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        check({tag, ".wren1"},   64'(bus.wren1),   64'(en));
        check({tag, ".wraddr1"}, 64'(bus.wraddr1), 64'(a));
        check({tag, ".wrdata1"}, 64'(bus.wrdata1), 64'(d));
    endtask

    task automatic chk_p2(input string tag, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        check({tag, ".wren2"},   64'(bus.wren2),   64'(en));
        check({tag, ".wraddr2"}, 64'(bus.wraddr2), 64'(a));
        check({tag, ".wrdata2"}, 64'(bus.wrdata2), 64'(d));
    endtask

    task automatic chk_rdy(input string tag, input logic [NB_REQ-1:0] exp);
        check({tag, ".req_ready"}, 64'(bus.req_ready), 64'(exp));
    endtask

    initial begin
        aresetn       = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        for (int i = 0; i < 4; i++) begin
            set_req(i, AW'(8'h10 + i), DW'(32'hA0 + i));
        end

        // Reset held with all requesters valid
        #3;
        chk_rdy("rst", 4'b0000);
        chk_p1("rst", 1'b0, 8'h00, 32'h0);
        chk_p2("rst", 1'b0, 8'h00, 32'h0);
`ifdef MEDURAM_WR_SAME_ADDR_CHECK_EN
        check("rst.conflict_cnt", 64'(conflict_cnt), 64'd0);
`endif
        #9;
        aresetn = 1'b1;
        #1;
        chk_rdy("rel", 4'b0011);

        // Rotation with all four valid
        tick();
        chk_p1("rot0", 1'b1, 8'h10, 32'hA0);
        chk_p2("rot0", 1'b1, 8'h11, 32'hA1);
        chk_rdy("rot0", 4'b1100);
        tick();
        chk_p1("rot1", 1'b1, 8'h12, 32'hA2);
        chk_p2("rot1", 1'b1, 8'h13, 32'hA3);
        chk_rdy("rot1", 4'b0011);
        tick();
        chk_p1("rot2", 1'b1, 8'h10, 32'hA0);
        chk_p2("rot2", 1'b1, 8'h11, 32'hA1);

        // Idle: no grants, strobes low, data held, pointer unchanged (ptr=2)
        bus.req_valid = 4'b0000;
        #1;
        chk_rdy("idle", 4'b0000);
        tick();
        chk_p1("idle", 1'b0, 8'h10, 32'hA0);
        chk_p2("idle", 1'b0, 8'h11, 32'hA1);
        bus.req_valid = 4'b1111;
        #1;
        chk_rdy("idle.ptr", 4'b1100);
        bus.req_valid = 4'b0000;

        // Single requester 3, pointer wraps to 0
        set_req(3, 8'hFF, 32'hDEADBEEF);
        bus.req_valid = 4'b1000;
        #1;
        chk_rdy("single", 4'b1000);
        tick();
        chk_p1("single", 1'b1, 8'hFF, 32'hDEADBEEF);
        chk_p2("single", 1'b0, 8'h11, 32'hA1);
        bus.req_valid = 4'b1111;
        #1;
        chk_rdy("wrap.ptr", 4'b0011);
        bus.req_valid = 4'b0000;

        // Same-address pair at requesters 0 and 1
        set_req(0, 8'h42, 32'h11111111);
        set_req(1, 8'h42, 32'h22222222);
        bus.req_valid = 4'b0011;
        #1;
`ifdef MEDURAM_WR_SAME_ADDR_CHECK_EN
        chk_rdy("conf0", 4'b0001);
        tick();
        chk_p1("conf0", 1'b1, 8'h42, 32'h11111111);
        check("conf0.wren2", 64'(bus.wren2), 64'd0);
        check("conf0.conflict_cnt", 64'(conflict_cnt), 64'd1);
        bus.req_valid = 4'b0010;
        #1;
        chk_rdy("conf1", 4'b0010);
        tick();
        chk_p1("conf1", 1'b1, 8'h42, 32'h22222222);
        check("conf1.wren2", 64'(bus.wren2), 64'd0);
        check("conf1.conflict_cnt", 64'(conflict_cnt), 64'd1);
`else
        chk_rdy("conf", 4'b0011);
        tick();
        chk_p1("conf", 1'b1, 8'h42, 32'h11111111);
        chk_p2("conf", 1'b1, 8'h42, 32'h22222222);
`endif
        bus.req_valid = 4'b0000;

        // Reset asserted after a grant was registered, before its strobe completes
        set_req(2, 8'h55, 32'hCAFEF00D);
        bus.req_valid = 4'b0100;
        #1;
        chk_rdy("mid", 4'b0100);
        tick();
        chk_p1("mid.pre", 1'b1, 8'h55, 32'hCAFEF00D);
        aresetn       = 1'b0;
        bus.req_valid = 4'b1111;
        #1;
        chk_rdy("mid.rst", 4'b0000);
        chk_p1("mid.rst", 1'b0, 8'h00, 32'h0);
        chk_p2("mid.rst", 1'b0, 8'h00, 32'h0);
`ifdef MEDURAM_WR_SAME_ADDR_CHECK_EN
        check("mid.rst.conflict_cnt", 64'(conflict_cnt), 64'd0);
`endif
        tick();
        check("mid.hold.wren1", 64'(bus.wren1), 64'd0);
        chk_rdy("mid.hold", 4'b0000);
        aresetn = 1'b1;
        #1;
        chk_rdy("mid.rel", 4'b0011);
        bus.req_valid = 4'b0000;
        tick();
        check("end.wren1", 64'(bus.wren1), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
